// File: rtl/signed_cmp_arb_pkg.sv
// Shared types and the round-robin pick function for signed_cmp_arbiter.
// CMP2 is only reached when SIGNED_CMP_ARB_PIPE_EN is defined.
package signed_cmp_arb_pkg;

    localparam int MAX_NREQ = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        CMP2 = 2'd2,
        RSP  = 2'd3
    } state_t;

    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
    } cmp_res_t;

    // Search begins one past the previous winner and wraps, so the last winner is served last.
    function automatic logic [MAX_NREQ-1:0] rr_pick(
        input logic [MAX_NREQ-1:0] valid,
        input logic [2:0]          last,
        input int                  nreq
    );
        logic [MAX_NREQ-1:0] grant;
        int                  idx;
        grant = '0;
        for (int k = 1; k <= MAX_NREQ; k++) begin
            idx = int'(last) + k;
            if (idx >= nreq) idx = idx - nreq;
            if (k <= nreq && grant == '0 && valid[idx[2:0]]) grant[idx[2:0]] = 1'b1;
        end
        return grant;
    endfunction

endpackage

// File: rtl/signed_cmp_arbiter_core.sv
// Combinational two's-complement comparator shared by all requesters.
module cmp_signed_core #(
    parameter int W = 4
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic                eq_o,
    output logic                gt_o,
    output logic                lt_o
);

    assign eq_o = (a_i == b_i);
    assign gt_o = (a_i > b_i);
    assign lt_o = (a_i < b_i);

endmodule

// File: rtl/signed_cmp_arbiter.sv
// Round-robin arbiter sharing one signed comparator among NREQ requesters.
// Define SIGNED_CMP_ARB_PIPE_EN to add a CMP2 stage that registers the raw comparator outputs.
module signed_cmp_arbiter
    import signed_cmp_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 4,
    localparam int IDW = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_eq,
    output logic              rsp_gt,
    output logic              rsp_lt,
    output logic              busy
);

    state_t                state_q, state_d;
    logic [IDW-1:0]        last_q, last_d;
    logic signed [W-1:0]   a_q, b_q;
    logic [IDW-1:0]        id_q;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]        rsp_id_q, rsp_id_d;
    cmp_res_t              res_q, res_d;
    cmp_res_t              core_res;
    logic                  eq_w, gt_w, lt_w;
    logic [MAX_NREQ-1:0]   valid_ext, pick;
    logic [2:0]            last_ext;
    logic [NREQ-1:0]       grant;
    logic [IDW-1:0]        grant_id;
    logic                  hs;
    logic                  load_rsp;

    always_comb begin
        valid_ext = '0;
        valid_ext[NREQ-1:0] = req_valid;
        last_ext = '0;
        last_ext[IDW-1:0] = last_q;
        pick = rr_pick(valid_ext, last_ext, NREQ);
        grant = pick[NREQ-1:0];
        grant_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) grant_id = IDW'(i);
        end
    end

    assign hs = |(req_valid & req_ready);

    // Stage boundary: operand and id latch at the handshake
    always_ff @(posedge clk) begin
        if (hs) begin
            a_q  <= req_a[grant_id*W +: W];
            b_q  <= req_b[grant_id*W +: W];
            id_q <= grant_id;
        end
    end

    cmp_signed_core #(.W(W)) u_core (
        .a_i  (a_q),
        .b_i  (b_q),
        .eq_o (eq_w),
        .gt_o (gt_w),
        .lt_o (lt_w)
    );

    assign core_res = '{eq: eq_w, gt: gt_w, lt: lt_w};

`ifdef SIGNED_CMP_ARB_PIPE_EN
    cmp_res_t pipe_q;

    // Stage boundary: raw comparator flags registered in CMP
    always_ff @(posedge clk) begin
        if (state_q == CMP) pipe_q <= core_res;
    end

    assign load_rsp = (state_q == CMP2);
`else
    assign load_rsp = (state_q == CMP);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (hs) state_d = CMP;
`ifdef SIGNED_CMP_ARB_PIPE_EN
            CMP:  state_d = CMP2;
            CMP2: state_d = RSP;
`else
            CMP:  state_d = RSP;
            CMP2: state_d = IDLE;
`endif
            RSP:  if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant is suppressed during reset so nothing handshakes while the arbiter is held.
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && rst_n) req_ready = grant;
        busy = (state_q != IDLE);
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        res_d       = res_q;
        last_d      = last_q;
        if (load_rsp) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = id_q;
`ifdef SIGNED_CMP_ARB_PIPE_EN
            res_d       = pipe_q;
`else
            res_d       = core_res;
`endif
        end else if (state_q == RSP && rsp_ready) begin
            rsp_valid_d = 1'b0;
            last_d      = rsp_id_q;
        end
    end

    // Stage boundary: response register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            res_q       <= '0;
            last_q      <= IDW'(NREQ - 1);
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            res_q       <= res_d;
            last_q      <= last_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_eq    = res_q.eq;
    assign rsp_gt    = res_q.gt;
    assign rsp_lt    = res_q.lt;

endmodule
